// File: rtl/systolic_2x2_accel_collector.sv
// Collects per-body partial accelerations from four array ports into accumulators,
// then streams one summed vector per body over a valid/ready handshake.
// Vector components are DW-bit two's-complement fixed point (Q16.16 with the default DW).
module systolic_2x2_accel_collector #(
  parameter int unsigned N_BODIES    = 4,
  parameter int unsigned EXP_CONTRIB = 2,
  parameter int unsigned IDXW        = 2,
  parameter int unsigned DW          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     last,
  input  logic [3:0]               in_vld,
  input  logic [3:0][IDXW-1:0]     in_idx,
  input  logic [2:0][DW-1:0]       in_pr_0,
  input  logic [2:0][DW-1:0]       in_pr_1,
  input  logic [2:0][DW-1:0]       in_pd_0,
  input  logic [2:0][DW-1:0]       in_pd_1,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [IDXW-1:0]          a_idx,
  output logic [2:0][DW-1:0]       a_vec,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned NP = 4;
  localparam int unsigned NC = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  state_e                                state_q, state_d;
  logic [IDXW-1:0]                       ptr_q, ptr_d;
  logic [N_BODIES-1:0][NC-1:0][DW-1:0]   acc_q, acc_d;
  logic [N_BODIES-1:0][CW-1:0]           cnt_q, cnt_d;
  logic                                  a_valid_q, a_valid_d;
  logic [IDXW-1:0]                       a_idx_q, a_idx_d;
  logic [NC-1:0][DW-1:0]                 a_vec_q, a_vec_d;
  logic                                  busy_q, busy_d;
  logic                                  err_q, err_d;

  logic [NP-1:0][NC-1:0][DW-1:0]         in_vec_c;
  logic [NP-1:0]                         hit_c;
  logic [IDXW-1:0]                       ptr_inc_c;

  assign in_vec_c  = {in_pd_1, in_pd_0, in_pr_1, in_pr_0};
  assign ptr_inc_c = ptr_q + IDXW'(1);

  // A port whose index names no body is dropped and flagged.
  always_comb begin
    hit_c = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      for (int unsigned b = 0; b < N_BODIES; b++) begin
        if (in_idx[k] == IDXW'(b)) hit_c[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    a_valid_d = a_valid_q;
    a_idx_d   = a_idx_q;
    a_vec_d   = a_vec_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          ptr_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        for (int unsigned k = 0; k < NP; k++) begin
          if (in_vld[k] && !hit_c[k]) err_d = 1'b1;
          for (int unsigned b = 0; b < N_BODIES; b++) begin
            if (in_vld[k] && (in_idx[k] == IDXW'(b))) begin
              cnt_d[b] = cnt_d[b] + CW'(1);
              for (int unsigned c = 0; c < NC; c++) begin
                acc_d[b][c] = acc_d[b][c] + in_vec_c[k][c];
              end
            end
          end
        end
        // First result is presented straight from the updated sums.
        if (last) begin
          state_d   = DRAIN;
          ptr_d     = '0;
          a_valid_d = 1'b1;
          a_idx_d   = '0;
          a_vec_d   = acc_d[0];
        end
      end
      DRAIN: begin
        if (a_ready) begin
          if (cnt_q[ptr_q] != CW'(EXP_CONTRIB)) err_d = 1'b1;
          if (ptr_q == IDXW'(N_BODIES - 1)) begin
            state_d   = IDLE;
            ptr_d     = '0;
            a_valid_d = 1'b0;
            a_idx_d   = '0;
            a_vec_d   = '0;
          end else begin
            ptr_d   = ptr_inc_c;
            a_idx_d = ptr_inc_c;
            a_vec_d = acc_q[ptr_inc_c];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      a_valid_q <= 1'b0;
      a_idx_q   <= '0;
      a_vec_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      a_valid_q <= a_valid_d;
      a_idx_q   <= a_idx_d;
      a_vec_q   <= a_vec_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign a_valid = a_valid_q;
  assign a_idx   = a_idx_q;
  assign a_vec   = a_vec_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
